// File: rtl/mc10_pkg.sv
// mc10_pkg: shared definitions for the MC-10 bus controller.
//   state_t       - bus FSM states (IDLE, ACCESS, EXP_WAIT, DONE)
//   region_t      - decoded target of a CPU cycle
//   *_BASE        - start addresses of the internal memory-map regions
//   UNMAPPED_DATA - value returned for reads nobody answers
package mc10_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_EXP_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        RGN_UNMAPPED = 3'd0,
        RGN_RAM      = 3'd1,
        RGN_IO       = 3'd2,
        RGN_ROM      = 3'd3,
        RGN_EXP      = 3'd4
    } region_t;

    localparam logic [15:0] RAM_BASE = 16'h4000;
    localparam logic [15:0] IO_BASE  = 16'h8000;
    localparam logic [15:0] ROM_BASE = 16'hC000;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

    // Keyboard reads float the two unused upper bits high.
    localparam logic [1:0] KBD_PAD = 2'b11;

endpackage

// File: rtl/mc10_addr_dec.sv
// mc10_addr_dec: combinational address decoder.
//   cpu_addr [15:0] in  - CPU address
//   exp_sel         in  - expansion claims the cycle, overriding the map
//   region          out - decoded target region
module mc10_addr_dec
    import mc10_pkg::*;
(
    input  logic [15:0] cpu_addr,
    input  logic        exp_sel,
    output region_t     region
);

    always_comb begin
        region = RGN_UNMAPPED;
        if (exp_sel) begin
            region = RGN_EXP;
        end else if (cpu_addr >= ROM_BASE) begin
            region = RGN_ROM;
        end else if (cpu_addr >= IO_BASE) begin
            region = RGN_IO;
        end else if (cpu_addr >= RAM_BASE) begin
            region = RGN_RAM;
        end
    end

endmodule

// File: rtl/mc10_bus_ctrl.sv
// mc10_bus_ctrl: MC-10 CPU bus controller (RAM / I/O latch / ROM / expansion).
//   clk_sys, reset_n           - clock, asynchronous active-low reset
//   cpu_ce, cpu_addr, cpu_rw,
//   cpu_dout                   - CPU cycle request, address, direction, write data
//   rom_dout, ram_dout,
//   exp_din, kbd_rows          - read data sources
//   exp_sel, exp_ack           - expansion claim and completion
//   data_bus                   - registered read data back to the CPU
//   ram_addr, ram_we, rom_cs   - internal memory strobes
//   exp_req, cpu_hold, bus_err - expansion handshake, CPU stall, timeout error
//   io_latch                   - write-only video/sound/control latch
//   state_dbg                  - current FSM state
//
// Handshake: cpu_ce is a one-cycle request that is accepted only in IDLE and
// never queued; the address, direction and write data are captured on
// acceptance. While the expansion owns the cycle, exp_req and cpu_hold are
// both high and exp_ack is only observed then; every accepted cycle ends with
// exactly one DONE cycle before IDLE.
module mc10_bus_ctrl
    import mc10_pkg::*;
#(
    parameter int  RAM_KB       = 4,
    parameter int  EXP_WAIT_MAX = 15,
    parameter int  IO_BITS      = 6,
    localparam int RAM_AW       = $clog2(RAM_KB * 1024)
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               cpu_ce,
    input  logic [15:0]        cpu_addr,
    input  logic               cpu_rw,
    input  logic [7:0]         cpu_dout,
    input  logic [7:0]         rom_dout,
    input  logic [7:0]         ram_dout,
    input  logic [7:0]         exp_din,
    input  logic [5:0]         kbd_rows,
    input  logic               exp_sel,
    input  logic               exp_ack,
    output logic [7:0]         data_bus,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic               ram_we,
    output logic               rom_cs,
    output logic               exp_req,
    output logic               cpu_hold,
    output logic               bus_err,
    output logic [IO_BITS-1:0] io_latch,
    output logic [1:0]         state_dbg
);

    if (!(RAM_KB == 4 || RAM_KB == 8 || RAM_KB == 16)) begin : g_bad_ram_kb
        $error("mc10_bus_ctrl: RAM_KB must be 4, 8 or 16");
    end
    if (EXP_WAIT_MAX < 1 || EXP_WAIT_MAX > 255) begin : g_bad_wait
        $error("mc10_bus_ctrl: EXP_WAIT_MAX must be in 1..255");
    end
    if (IO_BITS < 1 || IO_BITS > 8) begin : g_bad_io_bits
        $error("mc10_bus_ctrl: IO_BITS must be in 1..8");
    end

    // The counter starts at 0 on the first EXP_WAIT cycle, so the cycle in
    // which it holds EXP_WAIT_MAX-1 is the last one the expansion gets.
    localparam logic [7:0] WAIT_LAST = 8'(EXP_WAIT_MAX - 1);

    state_t              state;
    state_t              state_nx;
    region_t             region;
    region_t             region_q;
    logic                rw_q;
    logic [7:0]          wdata_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic [7:0]          wait_cnt;
    logic                timeout_q;
    logic                wait_last;
    logic [7:0]          rd_data;
    logic                unused_wdata;

    mc10_addr_dec u_addr_dec (
        .cpu_addr (cpu_addr),
        .exp_sel  (exp_sel),
        .region   (region)
    );

    assign wait_last = (wait_cnt == WAIT_LAST);

    // Only the top IO_BITS of the write data reach the latch.
    assign unused_wdata = ^wdata_q;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cpu_ce) begin
                    state_nx = (region == RGN_EXP) ? ST_EXP_WAIT : ST_ACCESS;
                end
            end
            ST_ACCESS:   state_nx = ST_DONE;
            ST_EXP_WAIT: begin
                if (exp_ack || wait_last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Strobes are decoded from registered state only, so an asynchronous
    // reset drops them immediately and aborts any write in flight.
    always_comb begin
        ram_we   = 1'b0;
        rom_cs   = 1'b0;
        exp_req  = 1'b0;
        cpu_hold = 1'b0;
        bus_err  = 1'b0;
        if (state == ST_ACCESS) begin
            ram_we = (region_q == RGN_RAM) && !rw_q;
            rom_cs = (region_q == RGN_ROM) && rw_q;
        end
        if (state == ST_EXP_WAIT) begin
            exp_req  = 1'b1;
            cpu_hold = 1'b1;
        end
        if (state == ST_DONE) begin
            bus_err = timeout_q;
        end
    end

    always_comb begin
        rd_data = UNMAPPED_DATA;
        case (region_q)
            RGN_RAM: rd_data = ram_dout;
            RGN_IO:  rd_data = {KBD_PAD, kbd_rows};
            RGN_ROM: rd_data = rom_dout;
            default: rd_data = UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            region_q   <= RGN_UNMAPPED;
            rw_q       <= 1'b1;
            wdata_q    <= 8'h00;
            ram_addr_q <= '0;
            wait_cnt   <= 8'h00;
            timeout_q  <= 1'b0;
            data_bus   <= UNMAPPED_DATA;
            io_latch   <= '0;
        end else begin
            state <= state_nx;

            if (state == ST_IDLE && cpu_ce) begin
                region_q   <= region;
                rw_q       <= cpu_rw;
                wdata_q    <= cpu_dout;
                ram_addr_q <= cpu_addr[RAM_AW-1:0];
            end

            if (state == ST_EXP_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'h00;
            end

            // Ack takes priority over a timeout landing on the same cycle.
            timeout_q <= (state == ST_EXP_WAIT) && !exp_ack && wait_last;

            if (state == ST_ACCESS && rw_q) begin
                data_bus <= rd_data;
            end else if (state == ST_EXP_WAIT && rw_q) begin
                if (exp_ack) begin
                    data_bus <= exp_din;
                end else if (wait_last) begin
                    data_bus <= UNMAPPED_DATA;
                end
            end

            if (state == ST_ACCESS && !rw_q && region_q == RGN_IO) begin
                io_latch <= wdata_q[7 -: IO_BITS];
            end
        end
    end

    assign ram_addr  = ram_addr_q;
    assign state_dbg = state;

endmodule

// File: doc/mc10_bus_ctrl.md
MC10_BUS_CTRL -- requirements
Module: mc10_bus_ctrl

Interface
REQ-001 Parameter RAM_KB, default 4, internal RAM size in KiB; legal values 4, 8, 16 only; any other value is an elaboration error.
REQ-002 Parameter EXP_WAIT_MAX, default 15, expansion wait timeout in clk_sys cycles; legal range 1..255.
REQ-003 Parameter IO_BITS, default 6, width of the write-only I/O latch; legal range 1..8.
REQ-004 Clock and reset: one clock, clk_sys; reset is asynchronous and active-low, named reset_n.
REQ-005 clk_sys  in  1  system clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cpu_ce  in  1  one-cycle strobe marking a valid CPU bus address.
REQ-008 cpu_addr  in  16  CPU address.
REQ-009 cpu_rw  in  1  1 = read, 0 = write.
REQ-010 cpu_dout  in  8  CPU write data.
REQ-011 rom_dout, ram_dout, exp_din  in  8 each  read data from ROM, RAM and expansion.
REQ-012 kbd_rows  in  6  active-high keyboard row data.
REQ-013 exp_sel  in  1  expansion overrides all internal decoding.
REQ-014 exp_ack  in  1  expansion cycle complete.
REQ-015 data_bus  out  8  registered CPU read data.
REQ-016 ram_addr  out  log2(RAM_KB*1024)  RAM address.
REQ-017 ram_we, rom_cs, exp_req, cpu_hold, bus_err  out  1 each  strobes and handshake signals.
REQ-018 io_latch  out  IO_BITS  latched video, sound and control bits.

Function
REQ-019 Address decode is taken when cpu_ce=1:
  - exp_sel=1: expansion.
  - $4000-$7FFF: RAM, mirrored modulo RAM_KB*1024.
  - $8000-$BFFF: I/O.
  - $C000-$FFFF: ROM.
  - $0000-$3FFF with exp_sel=0: unmapped.
REQ-020 FSM states are IDLE, ACCESS, EXP_WAIT and DONE.
  - IDLE -> ACCESS on cpu_ce for an internal or unmapped target.
  - IDLE -> EXP_WAIT on cpu_ce for an expansion target.
  - ACCESS -> DONE after 1 cycle.
  - EXP_WAIT -> DONE on exp_ack or on timeout.
  - DONE -> IDLE after 1 cycle.
REQ-021 cpu_ce in any state other than IDLE is ignored, and the access is not queued.
REQ-022 RAM write: ram_we is high for exactly the ACCESS cycle, with ram_addr stable from ACCESS through DONE.
REQ-023 I/O write: io_latch <= cpu_dout[7:8-IO_BITS] at the end of ACCESS.
REQ-024 I/O read: returns kbd_rows in bits 5:0 and 1 in bits 7:6; the read does not affect io_latch.
REQ-025 rom_cs is high during ACCESS for ROM reads only; writes to ROM are discarded.
REQ-026 Read data is registered into data_bus on the ACCESS->DONE or EXP_WAIT->DONE transition, giving a 2-cycle latency for internal reads.
REQ-027 data_bus holds its value until the next read completes; writes do not change data_bus.
REQ-028 Unmapped reads return 8'hFF; unmapped writes are discarded.
REQ-029 EXP_WAIT behaviour:
  - exp_req=1 and cpu_hold=1.
  - The wait counter starts at 0 and increments each cycle.
  - exp_ack sampled 1 captures exp_din on reads.
  - If the counter reaches EXP_WAIT_MAX with no ack: data_bus=8'hFF and bus_err pulses for 1 cycle in DONE.
REQ-030 If exp_ack and timeout coincide, exp_ack wins and bus_err is not asserted.
REQ-031 cpu_hold is low in all states except EXP_WAIT.
REQ-032 exp_ack seen outside EXP_WAIT is ignored.

Reset
REQ-033 On reset_n=0, asynchronously:
  - FSM goes to IDLE.
  - data_bus=8'hFF; io_latch=0.
  - ram_we, rom_cs, exp_req, cpu_hold and bus_err go to 0.
  - The wait counter is cleared.
REQ-034 Reset asserted mid-access aborts the access: no RAM write completes and no latch update occurs.
REQ-035 Reset is released synchronously by the integrator.

Structure
REQ-036 The shared package mc10_pkg holds the state enum, the region base constants ($4000, $8000, $C000) and the unmapped read value 8'hFF.
REQ-037 There is one sub-module, mc10_addr_dec: purely combinational, mapping cpu_addr and exp_sel to a region code.

Verification
REQ-038 RAM_KB=4: write $AA to $4005, then read $5005 -> data_bus=$AA 2 cycles after cpu_ce (mirror).
REQ-039 Write $FC to $BFFF -> io_latch=6'b111111; then read $BFFF with kbd_rows=6'h15 -> data_bus=$D5.
REQ-040 Expansion read with exp_ack at wait cycle 3 and exp_din=$5A -> cpu_hold high for 3 cycles, data_bus=$5A, bus_err=0.
REQ-041 Expansion read with no ack, EXP_WAIT_MAX=15 -> cpu_hold high for 15 cycles, data_bus=$FF, one-cycle bus_err.
REQ-042 reset_n pulsed low during an ACCESS RAM write -> RAM is unchanged and all outputs take their reset values immediately.
REQ-043 Read $2000 with exp_sel=0 -> data_bus=$FF; write to $C000 -> rom_cs stays low and there is no effect.
